// File: rtl/check_window_ctrl.sv
// check_window_ctrl: sequences one self-checking run.
//   IDLE -> WARM (WARMUP cycles, checking disabled) -> CHECK (WINDOW cycles,
//   failing samples counted, early stop at MAX_FAIL) -> DONE (one cycle) -> IDLE.
//   disable_o feeds the "disable iff" of named properties in a test top.
// Optional feature: define CHECK_WINDOW_SVA_EN to compile in internal properties.
module check_window_ctrl #(
    parameter int WARMUP   = 10,
    parameter int WINDOW   = 16,
    parameter int MAX_FAIL = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             smp_valid_i,
    input  logic             smp_ok_i,
    output logic             disable_o,
    output logic             check_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] cyc_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_WARM  = 4'b0010,
        S_CHECK = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    // Phase counter is shared by WARM and CHECK, so size it for the longer one.
    localparam int PH_MAX = (WARMUP > WINDOW) ? WARMUP : WINDOW;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  WARM_LAST  = PH_W'(WARMUP);
    localparam logic [PH_W-1:0]  CHECK_LAST = PH_W'(WINDOW);
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAIL);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             disable_q, disable_d;
    logic             check_en_q, check_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cyc_inc;

    // Cycle counter saturates at all-ones rather than wrapping.
    assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CNT_ONE;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cyc_d   = cyc_q;
        fcnt_d  = fcnt_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        case (state_q)
            S_IDLE: begin
                // abort_i in IDLE suppresses a simultaneous start.
                if (start_i && !abort_i) begin
                    state_d = (WARMUP == 0) ? S_CHECK : S_WARM;
                    ph_d    = PH_ONE;
                    cyc_d   = CNT_ONE;
                    fcnt_d  = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_WARM: begin
                cyc_d = cyc_inc;
                if (ph_q == WARM_LAST) begin
                    state_d = S_CHECK;
                    ph_d    = PH_ONE;
                end else begin
                    ph_d = ph_q + PH_ONE;
                end
            end
            S_CHECK: begin
                cyc_d = cyc_inc;
                if (smp_valid_i && !smp_ok_i && (fcnt_q < FAIL_LIMIT)) begin
                    fcnt_d = fcnt_q + CNT_ONE;
                end
                // The increment reaching the limit ends the window on this same edge.
                if ((fcnt_d == FAIL_LIMIT) || (ph_q == CHECK_LAST)) begin
                    state_d = S_DONE;
                    pass_d  = (fcnt_d == '0);
                    fail_d  = (fcnt_d != '0);
                end else begin
                    ph_d = ph_q + PH_ONE;
                end
            end
            S_DONE: begin
                cyc_d   = cyc_inc;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE: counters freeze, results clear.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ph_d    = ph_q;
            cyc_d   = cyc_q;
            fcnt_d  = fcnt_q;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end

        disable_d  = (state_d != S_CHECK);
        check_en_d = (state_d == S_CHECK);
        busy_d     = (state_d == S_WARM) || (state_d == S_CHECK);
        done_d     = (state_d == S_DONE);
    end

    // State, counters and outputs register; reset forces checking disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            cyc_q      <= '0;
            fcnt_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            disable_q  <= 1'b1;
            check_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cyc_q      <= cyc_d;
            fcnt_q     <= fcnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            disable_q  <= disable_d;
            check_en_q <= check_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign disable_o  = disable_q;
    assign check_en_o = check_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign cyc_o      = cyc_q;
    assign fail_cnt_o = fcnt_q;

`ifdef CHECK_WINDOW_SVA_EN
    property p_onehot;
        @(posedge clk) disable iff (!rst_n) $onehot(state_q);
    endproperty
    property p_excl;
        @(posedge clk) disable iff (!rst_n) !(pass_o & fail_o);
    endproperty
    property p_done_pulse;
        @(posedge clk) disable iff (!rst_n) done_o |=> !done_o;
    endproperty
    property p_fail_bound;
        @(posedge clk) disable iff (!rst_n) fail_cnt_o <= FAIL_LIMIT;
    endproperty
    property p_en_inv;
        @(posedge clk) disable iff (!rst_n) check_en_o == !disable_o;
    endproperty

    a_onehot:     assert property (p_onehot)     else $error("state not one-hot");
    a_excl:       assert property (p_excl)       else $error("pass_o and fail_o both set");
    a_done_pulse: assert property (p_done_pulse) else $error("done_o longer than one cycle");
    a_fail_bound: assert property (p_fail_bound) else $error("fail_cnt_o above MAX_FAIL");
    a_en_inv:     assert property (p_en_inv)     else $error("check_en_o not inverse of disable_o");
`endif

endmodule

// File: tb/tb_check_window_ctrl.sv
// Directed bench for check_window_ctrl: default-parameter instance plus a
// WARMUP=0 instance used for the immediate-CHECK and async-reset cases.
module tb_check_window_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start_i, abort_i, smp_valid_i, smp_ok_i;
    logic       disable_o, check_en_o, busy_o, done_o, pass_o, fail_o;
    logic [7:0] cyc_o, fail_cnt_o;

    logic       rst0_n, start0_i;
    logic       disable0_o, check_en0_o, busy0_o, done0_o, pass0_o, fail0_o;
    logic [7:0] cyc0_o, fail_cnt0_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    check_window_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .smp_valid_i(smp_valid_i), .smp_ok_i(smp_ok_i),
        .disable_o(disable_o), .check_en_o(check_en_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .cyc_o(cyc_o), .fail_cnt_o(fail_cnt_o)
    );

    check_window_ctrl #(.WARMUP(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .start_i(start0_i), .abort_i(1'b0),
        .smp_valid_i(1'b0), .smp_ok_i(1'b1),
        .disable_o(disable0_o), .check_en_o(check_en0_o), .busy_o(busy0_o),
        .done_o(done0_o), .pass_o(pass0_o), .fail_o(fail0_o),
        .cyc_o(cyc0_o), .fail_cnt_o(fail_cnt0_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full run: fail masks are indexed by 1-based WARM / CHECK cycle number.
    task automatic run_check(input string name, input logic [31:0] chk_mask,
                             input logic [31:0] warm_mask, input int exp_warm,
                             input int exp_chk, input int exp_cyc,
                             input logic exp_pass, input int exp_fcnt);
        int         warm_n = 0;
        int         chk_n  = 0;
        logic       seen   = 1'b0;
        logic [7:0] dcyc   = '0;
        logic [7:0] dfc    = '0;
        logic       dp     = 1'b0;
        logic       df     = 1'b0;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        check_val({name, " start cyc"}, cyc_o, 1);
        check_val({name, " start pass clr"}, pass_o, 0);
        check_val({name, " start fail clr"}, fail_o, 0);
        check_val({name, " start fcnt clr"}, fail_cnt_o, 0);
        for (int k = 0; k < 200 && !seen; k++) begin
            smp_valid_i = 1'b0;
            smp_ok_i    = 1'b1;
            if (done_o) begin
                seen = 1'b1;
                dcyc = cyc_o;
                dp   = pass_o;
                df   = fail_o;
                dfc  = fail_cnt_o;
            end else begin
                if (check_en_o) begin
                    chk_n++;
                    smp_valid_i = 1'b1;
                    smp_ok_i    = !chk_mask[chk_n];
                end else if (busy_o) begin
                    warm_n++;
                    smp_valid_i = 1'b1;
                    smp_ok_i    = !warm_mask[warm_n];
                end
                tick;
            end
        end
        smp_valid_i = 1'b0;
        smp_ok_i    = 1'b1;
        check_val({name, " done seen"}, seen, 1);
        check_val({name, " warm cycles"}, warm_n, exp_warm);
        check_val({name, " check cycles"}, chk_n, exp_chk);
        check_val({name, " done cyc"}, dcyc, exp_cyc);
        check_val({name, " pass"}, dp, exp_pass);
        check_val({name, " fail"}, df, !exp_pass);
        check_val({name, " fail_cnt"}, dfc, exp_fcnt);
        check_val({name, " disable in done"}, disable_o, 1);
        // start during DONE must not launch a new run
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        check_val({name, " done pulse ends"}, done_o, 0);
        check_val({name, " start in done ignored"}, busy_o, 0);
        check_val({name, " result holds"}, pass_o, exp_pass);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rst0_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; smp_valid_i = 1'b0; smp_ok_i = 1'b1;
        start0_i = 1'b0;
        tick;
        check_val("reset disable", disable_o, 1);
        check_val("reset check_en", check_en_o, 0);
        check_val("reset busy", busy_o, 0);
        check_val("reset done", done_o, 0);
        check_val("reset pass", pass_o, 0);
        check_val("reset fail", fail_o, 0);
        check_val("reset cyc", cyc_o, 0);
        check_val("reset fcnt", fail_cnt_o, 0);
        rst_n = 1'b1; rst0_n = 1'b1;
        tick;

        run_check("all_ok", 32'h0, 32'h0, 10, 16, 27, 1'b1, 0);
        run_check("two_fail", (32'h1 << 5) | (32'h1 << 9), 32'h0, 10, 16, 27, 1'b0, 2);
        run_check("early_stop", 32'hE, 32'h0, 10, 3, 14, 1'b0, 3);
        run_check("last_cycle", 32'h1 << 16, 32'h0, 10, 16, 27, 1'b0, 1);
        run_check("warm_fail", 32'h0, 32'h7FE, 10, 16, 27, 1'b1, 0);

        // abort during WARM at cyc_o=5
        start_i = 1'b1; tick; start_i = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        check_val("abort pre cyc", cyc_o, 5);
        abort_i = 1'b1; tick; abort_i = 1'b0;
        check_val("abort busy", busy_o, 0);
        check_val("abort disable", disable_o, 1);
        check_val("abort done", done_o, 0);
        check_val("abort pass", pass_o, 0);
        check_val("abort fail", fail_o, 0);
        check_val("abort cyc kept", cyc_o, 5);
        tick;

        // new run: start during WARM ignored, then abort in CHECK keeps counters
        start_i = 1'b1; tick; start_i = 1'b0;
        tick; tick;
        start_i = 1'b1; tick; start_i = 1'b0;
        check_val("midrun start ignored", cyc_o, 4);
        for (int k = 0; k < 40 && !check_en_o; k++) tick;
        check_val("reach check", check_en_o, 1);
        check_val("check first cyc", cyc_o, 11);
        smp_valid_i = 1'b1; smp_ok_i = 1'b0; tick;
        smp_valid_i = 1'b0; smp_ok_i = 1'b1;
        abort_i = 1'b1; tick; abort_i = 1'b0;
        check_val("abort chk busy", busy_o, 0);
        check_val("abort chk done", done_o, 0);
        check_val("abort chk fcnt kept", fail_cnt_o, 1);
        check_val("abort chk cyc kept", cyc_o, 12);
        check_val("abort chk fail", fail_o, 0);
        abort_i = 1'b1; start_i = 1'b1; tick;
        abort_i = 1'b0; start_i = 1'b0;
        check_val("abort+start busy", busy_o, 0);
        check_val("abort+start cyc", cyc_o, 12);

        // WARMUP=0 instance: CHECK immediately, then asynchronous reset
        start0_i = 1'b1; tick; start0_i = 1'b0;
        check_val("w0 check_en", check_en0_o, 1);
        check_val("w0 disable", disable0_o, 0);
        check_val("w0 cyc", cyc0_o, 1);
        tick; tick;
        #2 rst0_n = 1'b0;
        #1;
        check_val("w0 async disable", disable0_o, 1);
        check_val("w0 async check_en", check_en0_o, 0);
        check_val("w0 async busy", busy0_o, 0);
        check_val("w0 async cyc", cyc0_o, 0);
        check_val("w0 async done", done0_o, 0);
        tick;
        rst0_n = 1'b1;
        tick;
        check_val("w0 stays idle", busy0_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
